// File: rtl/star_collect_ctrl.sv
// Star collection controller: one shared overlap comparator scanned over all stars once per frame.
// Optional last-star bonus is enabled by defining STAR_COLLECT_BONUS_EN.
module star_collect_ctrl #(
   parameter int NUM_STARS = 8,
   parameter int IDX_W     = 3,
   parameter int STAR_SIZE = 12,
   parameter int CHAR_SIZE = 12,
   parameter int SCORE_W   = 8,
   parameter int BONUS     = 10
) (
   input  logic                 sys_clk,
   input  logic                 RST,
   input  logic                 frame_tick,
   input  logic                 respawn,
   input  logic [9:0]           char_X,
   input  logic [9:0]           char_Y,
   output logic [IDX_W-1:0]     star_idx,
   input  logic [9:0]           star_wx,
   input  logic [9:0]           star_wy,
   output logic [NUM_STARS-1:0] en_mask,
   output logic                 touch_star,
   output logic [IDX_W-1:0]     touch_idx,
   output logic [SCORE_W-1:0]   score,
   output logic                 scan_busy,
   output logic                 scan_done,
   output logic                 scan_overrun,
   output logic                 all_collected
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_STARS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   // Sum width holds score plus the largest addend without wrapping.
   localparam int ADD_W = SCORE_W + $clog2(BONUS + 2);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     star_idx_q, star_idx_d;
   logic [9:0]           cx_q, cx_d;
   logic [9:0]           cy_q, cy_d;
   logic [NUM_STARS-1:0] en_mask_q, en_mask_d;
   logic                 touch_star_q, touch_star_d;
   logic [IDX_W-1:0]     touch_idx_q, touch_idx_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 scan_done_q, scan_done_d;
   logic                 scan_overrun_q, scan_overrun_d;
`ifdef STAR_COLLECT_BONUS_EN
   logic                 cleared_q, cleared_d;
`endif

   logic [10:0] sx_lo, sx_hi, sy_lo, sy_hi;
   logic [10:0] cx_lo, cx_hi, cy_lo, cy_hi;
   logic        xhit, yhit, hit;

   function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                    input logic [10:0] hi);
      return (p >= lo) && (p <= hi);
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input int unsigned b);
      logic [ADD_W-1:0] sum;
      sum = ADD_W'(a) + ADD_W'(b);
      return (sum > ADD_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
   endfunction

   // Overlap is evaluated against the frame snapshot, widened so edges near 1023 do not wrap.
   always_comb begin
      sx_lo = {1'b0, star_wx};
      sx_hi = sx_lo + 11'(STAR_SIZE);
      sy_lo = {1'b0, star_wy};
      sy_hi = sy_lo + 11'(STAR_SIZE);
      cx_lo = {1'b0, cx_q};
      cx_hi = cx_lo + 11'(CHAR_SIZE);
      cy_lo = {1'b0, cy_q};
      cy_hi = cy_lo + 11'(CHAR_SIZE);
      xhit  = in_span(cx_lo, sx_lo, sx_hi) || in_span(cx_hi, sx_lo, sx_hi);
      yhit  = in_span(cy_lo, sy_lo, sy_hi) || in_span(cy_hi, sy_lo, sy_hi);
      hit   = (state_q == SCAN) && xhit && yhit && en_mask_q[star_idx_q];
   end

   always_comb begin
      // NOTE: every _d takes a default first, so no path through this block can infer a latch.
      state_d        = state_q;
      star_idx_d     = star_idx_q;
      cx_d           = cx_q;
      cy_d           = cy_q;
      en_mask_d      = en_mask_q;
      touch_star_d   = 1'b0;
      touch_idx_d    = touch_idx_q;
      score_d        = score_q;
      scan_done_d    = 1'b0;
      scan_overrun_d = scan_overrun_q;
`ifdef STAR_COLLECT_BONUS_EN
      cleared_d      = cleared_q;
`endif

      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               cx_d       = char_X;
               cy_d       = char_Y;
               star_idx_d = '0;
               state_d    = SCAN;
`ifdef STAR_COLLECT_BONUS_EN
               cleared_d  = 1'b0;
`endif
            end
         end
         SCAN: begin
            if (frame_tick) scan_overrun_d = 1'b1;
            if (hit) begin
               en_mask_d[star_idx_q] = 1'b0;
               touch_star_d          = 1'b1;
               touch_idx_d           = star_idx_q;
               score_d               = sat_add(score_q, 1);
`ifdef STAR_COLLECT_BONUS_EN
               cleared_d             = 1'b1;
`endif
            end
            if (star_idx_q == LAST_IDX) begin
               state_d     = DONE;
               scan_done_d = 1'b1;
`ifdef STAR_COLLECT_BONUS_EN
               // Bonus lands with scan_done; only a scan that emptied the mask qualifies.
               if ((cleared_q || hit) && (en_mask_d == '0)) score_d = sat_add(score_d, BONUS);
`endif
            end else begin
               star_idx_d = star_idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (frame_tick) scan_overrun_d = 1'b1;
            state_d    = IDLE;
            star_idx_d = '0;
         end
         default: state_d = IDLE;
      endcase

      // Respawn overrides everything this cycle: scan aborted, touch and tick dropped, score kept.
      if (respawn) begin
         state_d        = IDLE;
         star_idx_d     = '0;
         en_mask_d      = '1;
         touch_star_d   = 1'b0;
         touch_idx_d    = touch_idx_q;
         score_d        = score_q;
         scan_done_d    = 1'b0;
         scan_overrun_d = scan_overrun_q;
         cx_d           = cx_q;
         cy_d           = cy_q;
`ifdef STAR_COLLECT_BONUS_EN
         cleared_d      = 1'b0;
`endif
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
   always_ff @(posedge sys_clk) begin
      if (RST) begin
         state_q        <= IDLE;
         star_idx_q     <= '0;
         cx_q           <= '0;
         cy_q           <= '0;
         en_mask_q      <= '1;
         touch_star_q   <= 1'b0;
         touch_idx_q    <= '0;
         score_q        <= '0;
         scan_done_q    <= 1'b0;
         scan_overrun_q <= 1'b0;
`ifdef STAR_COLLECT_BONUS_EN
         cleared_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         star_idx_q     <= star_idx_d;
         cx_q           <= cx_d;
         cy_q           <= cy_d;
         en_mask_q      <= en_mask_d;
         touch_star_q   <= touch_star_d;
         touch_idx_q    <= touch_idx_d;
         score_q        <= score_d;
         scan_done_q    <= scan_done_d;
         scan_overrun_q <= scan_overrun_d;
`ifdef STAR_COLLECT_BONUS_EN
         cleared_q      <= cleared_d;
`endif
      end
   end

   assign star_idx      = star_idx_q;
   assign en_mask       = en_mask_q;
   assign touch_star    = touch_star_q;
   assign touch_idx     = touch_idx_q;
   assign score         = score_q;
   assign scan_busy     = (state_q != IDLE);
   assign scan_done     = scan_done_q;
   assign scan_overrun  = scan_overrun_q;
   assign all_collected = (en_mask_q == '0);

endmodule

// File: tb/tb_star_collect_ctrl.sv
// Self-checking bench for star_collect_ctrl: directed scenarios plus randomized scans
// compared against a per-star overlap model; a second instance with SCORE_W=4 covers saturation.
`timescale 1ns/1ps
module tb_star_collect_ctrl;
   localparam int N     = 8;
   localparam int SS    = 12;
   localparam int CS    = 12;
   localparam int BONUS = 10;

   logic       sys_clk = 1'b0;
   logic       RST = 1'b1, frame_tick = 1'b0, respawn = 1'b0;
   logic [9:0] char_X = '0, char_Y = '0;
   logic [9:0] star_wx, star_wy, star_wx4, star_wy4;
   logic [2:0] star_idx, touch_idx, star_idx4, touch_idx4;
   logic [7:0] en_mask, en_mask4, score;
   logic [3:0] score4;
   logic       touch_star, scan_busy, scan_done, scan_overrun, all_collected;
   logic       touch_star4, scan_busy4, scan_done4, scan_overrun4, all_collected4;

   logic [9:0] tx[N], ty[N];
   assign star_wx  = tx[star_idx];
   assign star_wy  = ty[star_idx];
   assign star_wx4 = tx[star_idx4];
   assign star_wy4 = ty[star_idx4];

   always #5 sys_clk = ~sys_clk;

   star_collect_ctrl #(.NUM_STARS(N), .IDX_W(3), .STAR_SIZE(SS), .CHAR_SIZE(CS),
                       .SCORE_W(8), .BONUS(BONUS)) dut (
      .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick), .respawn(respawn),
      .char_X(char_X), .char_Y(char_Y), .star_idx(star_idx), .star_wx(star_wx),
      .star_wy(star_wy), .en_mask(en_mask), .touch_star(touch_star), .touch_idx(touch_idx),
      .score(score), .scan_busy(scan_busy), .scan_done(scan_done),
      .scan_overrun(scan_overrun), .all_collected(all_collected));

   star_collect_ctrl #(.NUM_STARS(N), .IDX_W(3), .STAR_SIZE(SS), .CHAR_SIZE(CS),
                       .SCORE_W(4), .BONUS(BONUS)) dut4 (
      .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick), .respawn(respawn),
      .char_X(char_X), .char_Y(char_Y), .star_idx(star_idx4), .star_wx(star_wx4),
      .star_wy(star_wy4), .en_mask(en_mask4), .touch_star(touch_star4), .touch_idx(touch_idx4),
      .score(score4), .scan_busy(scan_busy4), .scan_done(scan_done4),
      .scan_overrun(scan_overrun4), .all_collected(all_collected4));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [N-1:0] m_en;
   int           m_score, m_score4;
   bit           m_over;

   function automatic bit overlaps(input int cx, input int cy, input int sx, input int sy);
      bit xh, yh;
      xh = (cx >= sx && cx <= sx + SS) || (cx + CS >= sx && cx + CS <= sx + SS);
      yh = (cy >= sy && cy <= sy + SS) || (cy + CS >= sy && cy + CS <= sy + SS);
      return xh && yh;
   endfunction

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_far_table();
      for (int i = 0; i < N; i++) begin
         tx[i] = 10'(300 + 40 * i);
         ty[i] = 10'(700);
      end
   endtask

   task automatic do_respawn();
      respawn = 1'b1;
      step();
      respawn = 1'b0;
      m_en = '1;
      n_cmp++;
      if (en_mask !== 8'hFF || scan_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL respawn_idle: en_mask=%h busy=%b want FF/0", en_mask, scan_busy);
      end
   endtask

   // One full scan; tick_at/abort_at name the SCAN cycle (1..N) carrying an extra tick / respawn.
   task automatic run_scan(input int cx, input int cy, input int tick_at, input int abort_at);
      int cleared;
      char_X = 10'(cx);
      char_Y = 10'(cy);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      char_X = 10'($urandom);
      char_Y = 10'($urandom);
      n_cmp++;
      if (scan_busy !== 1'b1 || star_idx !== 3'd0) begin
         n_bad++;
         $display("FAIL scan_start: busy=%b idx=%0d want 1/0", scan_busy, star_idx);
      end
      cleared = 0;
      for (int j = 1; j <= N; j++) begin
         bit h, ab;
         ab = (j == abort_at);
         h  = m_en[j-1] && overlaps(cx, cy, tx[j-1], ty[j-1]);
         if (j == tick_at) frame_tick = 1'b1;
         if (ab) respawn = 1'b1;
         step();
         frame_tick = 1'b0;
         respawn    = 1'b0;
         if (j == tick_at && !ab) m_over = 1'b1;
         if (ab) begin
            m_en = '1;
            h    = 1'b0;
         end else if (h) begin
            m_en[j-1] = 1'b0;
            m_score   = sat(m_score + 1, 8);
            m_score4  = sat(m_score4 + 1, 4);
            cleared++;
         end
`ifdef STAR_COLLECT_BONUS_EN
         if (j == N && !ab && cleared > 0 && m_en == '0) begin
            m_score  = sat(m_score + BONUS, 8);
            m_score4 = sat(m_score4 + BONUS, 4);
         end
`endif
         n_cmp++;
         if (touch_star !== h || (h && touch_idx !== 3'(j - 1))) begin
            n_bad++;
            $display("FAIL touch[%0d]: touch=%b idx=%0d want %b/%0d", j - 1, touch_star,
                     touch_idx, h, j - 1);
         end
         n_cmp++;
         if (scan_done !== (j == N && !ab)) begin
            n_bad++;
            $display("FAIL scan_done[%0d]: got %b want %b", j, scan_done, (j == N && !ab));
         end
         n_cmp++;
         if (en_mask !== m_en || score !== 8'(m_score) || scan_overrun !== m_over) begin
            n_bad++;
            $display("FAIL state[%0d]: en=%h score=%0d ovr=%b want %h/%0d/%b", j, en_mask,
                     score, scan_overrun, m_en, m_score, m_over);
         end
         n_cmp++;
         if (scan_busy !== !ab || (!ab && j < N && star_idx !== 3'(j))) begin
            n_bad++;
            $display("FAIL progress[%0d]: busy=%b idx=%0d", j, scan_busy, star_idx);
         end
         if (ab) begin
            bit stray;
            stray = 1'b0;
            for (int t = 0; t < N + 2; t++) begin
               step();
               if (scan_done !== 1'b0 || touch_star !== 1'b0 || scan_busy !== 1'b0) stray = 1'b1;
            end
            n_cmp++;
            if (stray || en_mask !== 8'hFF || score !== 8'(m_score)) begin
               n_bad++;
               $display("FAIL abort: stray=%b en=%h score=%0d want 0/FF/%0d", stray, en_mask,
                        score, m_score);
            end
            return;
         end
      end
      step();
      n_cmp++;
      if (scan_done !== 1'b0 || scan_busy !== 1'b0 || star_idx !== 3'd0 || touch_star !== 1'b0) begin
         n_bad++;
         $display("FAIL scan_end: done=%b busy=%b idx=%0d touch=%b want 0/0/0/0", scan_done,
                  scan_busy, star_idx, touch_star);
      end
      n_cmp++;
      if (score !== 8'(m_score) || score4 !== 4'(m_score4) || all_collected !== (m_en == '0)) begin
         n_bad++;
         $display("FAIL totals: score=%0d score4=%0d all=%b want %0d/%0d/%b", score, score4,
                  all_collected, m_score, m_score4, (m_en == '0));
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      m_en = '1; m_score = 0; m_score4 = 0; m_over = 1'b0;
      n_cmp++;
      if (star_idx !== 3'd0 || en_mask !== 8'hFF || touch_star !== 1'b0 || touch_idx !== 3'd0 ||
          score !== 8'd0 || scan_done !== 1'b0 || scan_overrun !== 1'b0 || scan_busy !== 1'b0 ||
          all_collected !== 1'b0 || score4 !== 4'd0) begin
         n_bad++;
         $display("FAIL reset: idx=%0d en=%h touch=%b tidx=%0d score=%0d done=%b ovr=%b busy=%b",
                  star_idx, en_mask, touch_star, touch_idx, score, scan_done, scan_overrun,
                  scan_busy);
      end
   endtask

   task automatic test_basic();
      set_far_table();
      tx[0] = 10'd13;  ty[0] = 10'd326;
      tx[3] = 10'd100; ty[3] = 10'd200;
      run_scan(20, 330, 0, 0);
      n_cmp++;
      if (en_mask !== 8'hFE || score !== 8'd1) begin
         n_bad++;
         $display("FAIL basic: en=%h score=%0d want FE/1", en_mask, score);
      end
   endtask

   task automatic test_edges();
      do_respawn();
      run_scan(1, 326, 0, 0);
      n_cmp++;
      if (en_mask !== 8'hFE) begin
         n_bad++;
         $display("FAIL edge_hit: en=%h want FE", en_mask);
      end
      do_respawn();
      run_scan(26, 326, 0, 0);
      n_cmp++;
      if (en_mask !== 8'hFF) begin
         n_bad++;
         $display("FAIL edge_miss: en=%h want FF", en_mask);
      end
      tx[5] = 10'd1020; ty[5] = 10'd1020;
      run_scan(1015, 1015, 0, 0);
      n_cmp++;
      if (en_mask !== 8'hDF) begin
         n_bad++;
         $display("FAIL no_wrap: en=%h want DF", en_mask);
      end
      tx[5] = 10'd500; ty[5] = 10'd700;
   endtask

   task automatic test_respawn_tick();
      do_respawn();
      respawn = 1'b1;
      frame_tick = 1'b1;
      step();
      respawn = 1'b0;
      frame_tick = 1'b0;
      n_cmp++;
      if (scan_busy !== 1'b0 || scan_overrun !== 1'b0 || en_mask !== 8'hFF) begin
         n_bad++;
         $display("FAIL respawn_tick_idle: busy=%b ovr=%b en=%h want 0/0/FF", scan_busy,
                  scan_overrun, en_mask);
      end
      run_scan(20, 330, 2, 2);
      n_cmp++;
      if (scan_overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL respawn_tick_busy: ovr=%b want 0", scan_overrun);
      end
   endtask

   task automatic test_repeat_overrun();
      int s0;
      do_respawn();
      run_scan(20, 330, 0, 0);
      s0 = m_score;
      run_scan(20, 330, 3, 0);
      n_cmp++;
      if (scan_overrun !== 1'b1 || score !== 8'(s0) || en_mask !== 8'hFE) begin
         n_bad++;
         $display("FAIL repeat_overrun: ovr=%b score=%0d en=%h want 1/%0d/FE", scan_overrun,
                  score, en_mask, s0);
      end
   endtask

   task automatic test_all_stars();
      int s0, want;
      do_respawn();
      for (int i = 0; i < N; i++) begin
         tx[i] = 10'd50; ty[i] = 10'd50;
      end
      s0 = m_score;
      want = s0 + 8;
`ifdef STAR_COLLECT_BONUS_EN
      want = want + BONUS;
`endif
      run_scan(50, 50, 0, 0);
      n_cmp++;
      if (score !== 8'(want) || all_collected !== 1'b1 || en_mask !== 8'h00) begin
         n_bad++;
         $display("FAIL all_stars: score=%0d all=%b en=%h want %0d/1/00", score, all_collected,
                  en_mask, want);
      end
   endtask

   task automatic test_respawn_mid();
      int s0;
      do_respawn();
      run_scan(50, 50, 0, 3);
      s0 = m_score;
      n_cmp++;
      if (en_mask !== 8'hFF || score !== 8'(s0) || scan_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL respawn_mid: en=%h score=%0d busy=%b want FF/%0d/0", en_mask, score,
                  scan_busy, s0);
      end
   endtask

   task automatic test_saturation();
      for (int r = 0; r < 4 && m_score4 < 15; r++) begin
         do_respawn();
         for (int i = 0; i < N; i++) begin
            tx[i] = 10'd50; ty[i] = 10'd50;
         end
         run_scan(50, 50, 0, 0);
      end
      do_respawn();
      set_far_table();
      tx[0] = 10'd50; ty[0] = 10'd50;
      run_scan(50, 50, 0, 0);
      n_cmp++;
      if (score4 !== 4'd15 || touch_idx4 !== 3'd0) begin
         n_bad++;
         $display("FAIL saturate: score4=%0d want 15", score4);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         int base, cx, cy, tk, ab;
         base = ($urandom_range(0, 3) == 0) ? 960 : 0;
         for (int i = 0; i < N; i++) begin
            tx[i] = 10'(base + $urandom_range(0, 50));
            ty[i] = 10'(base + $urandom_range(0, 50));
         end
         cx = base + $urandom_range(0, 50);
         cy = base + $urandom_range(0, 50);
         tk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : 0;
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N) : 0;
         if ($urandom_range(0, 2) == 0) do_respawn();
         run_scan(cx, cy, tk, ab);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_far_table();
      test_reset();
      test_basic();
      test_edges();
      test_respawn_tick();
      test_repeat_overrun();
      test_all_stars();
      test_respawn_mid();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/star_collect_ctrl.md
Name: star_collect_ctrl

Overview:
Central controller for all collectible stars in a level. Once per frame it time-multiplexes a single shared overlap comparator across NUM_STARS world-space star positions and maintains the per-star enable bitmap. It also raises a touch event per collected star, keeps a saturating score, and supports level respawn. It sits between the character position logic and the star/score renderers, and replaces per-star collision instances.

Parameters:
NUM_STARS, 8, number of stars managed (2..16)
IDX_W, 3, width of star index, ceil(log2(NUM_STARS))
STAR_SIZE, 12, star bounding-box extent in pixels (box spans pos..pos+STAR_SIZE)
CHAR_SIZE, 12, character bounding-box extent in pixels
SCORE_W, 8, score counter width
BONUS, 10, bonus added when the last star is collected (only used with the optional feature)

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse that starts a scan
respawn  in  1  one-cycle pulse that re-enables all stars
char_X  in  10  character world X
char_Y  in  10  character world Y
star_idx  out  IDX_W  index of the star currently addressed in the external position table
star_wx  in  10  world X of star star_idx; combinational lookup, valid in the same cycle
star_wy  in  10  world Y of star star_idx; combinational lookup, valid in the same cycle
en_mask  out  NUM_STARS  bit i = 1 means star i is still present/drawn
touch_star  out  1  one-cycle pulse when a star is collected
touch_idx  out  IDX_W  index of the collected star; valid while touch_star = 1
score  out  SCORE_W  count of stars collected, saturating
scan_busy  out  1  high while in SCAN or DONE
scan_done  out  1  one-cycle pulse at the end of a scan
scan_overrun  out  1  sticky flag: a frame_tick arrived while a scan was busy
all_collected  out  1  high when en_mask == 0

Behaviour:
- Reset values (RST = 1 at an edge):
  - State IDLE; star_idx = 0; en_mask = all ones.
  - touch_star, touch_idx, score, scan_done, scan_overrun all = 0.
- FSM has three states:
  - IDLE: on frame_tick, snapshot char_X and char_Y into cx and cy, set star_idx = 0, go to SCAN.
  - SCAN: one star is evaluated per cycle. If star_idx == NUM_STARS-1, go to DONE; otherwise star_idx increments.
  - DONE: scan_done = 1 for this cycle only; return to IDLE with star_idx = 0.
- Timing:
  - Tick sampled at edge k: SCAN occupies edges k+1 .. k+NUM_STARS, DONE is the cycle after the last SCAN edge, scan_done is high for exactly one cycle.
  - Tick to scan_done = NUM_STARS+1 cycles.
- Overlap test is combinational in SCAN, using the snapshot cx/cy (not live char_X/char_Y).
  - All arithmetic is widened to 11 bits, so there is no wrap at 1023.
  - xhit = (cx >= sx and cx <= sx+STAR_SIZE) or (cx+CHAR_SIZE >= sx and cx+CHAR_SIZE <= sx+STAR_SIZE). yhit is the same with cy/sy.
  - hit = xhit and yhit and en_mask[star_idx].
- On hit, at the end of the SCAN cycle (registered):
  - en_mask[star_idx] clears.
  - touch_star = 1 and touch_idx = star_idx for the next cycle.
  - score increments, saturating at 2^SCORE_W - 1.
- A disabled star never produces a touch. Stars that do not overlap leave all state unchanged.
- frame_tick while busy is ignored and sets scan_overrun. scan_overrun clears only on RST.
- respawn, in any state:
  - en_mask becomes all ones; FSM goes to IDLE; star_idx = 0.
  - Any in-progress scan is aborted with no scan_done; a touch from that same cycle is discarded.
  - score is unchanged.
- respawn and frame_tick in the same cycle: respawn wins and the tick is dropped (not counted as overrun).
- all_collected is combinational from en_mask.

Optional Feature:
Macro STAR_COLLECT_BONUS_EN.
- Defined: in the DONE cycle, if this scan cleared at least one star and en_mask is now 0, score += BONUS (saturating), applied together with scan_done. The bonus is awarded once per respawn epoch.
- Undefined: no bonus logic; score changes only by 1 per touch, and BONUS is unused.

Test Plan:
- Reset, with table star0 = (13,326) and star3 = (100,200); char = (20,330); frame_tick -> touch_star pulse with touch_idx = 0, score = 1, en_mask = 8'hFE, scan_done 9 cycles after the tick.
- Edge overlap: char = (1,326) -> hit on star0 (cx+12 = 13). char = (26,326) -> no touch, en_mask stays 8'hFF.
- Repeat the tick at char = (20,330) after star0 is collected -> no touch, score stays 1. Tick during busy -> scan_overrun = 1 and the scan completes normally.
- Place all 8 stars at (50,50) with char = (50,50), one tick -> 8 consecutive touch pulses, idx 0..7, score = 8, all_collected = 1. With STAR_COLLECT_BONUS_EN, score = 18 when scan_done is asserted.
- respawn asserted at the third SCAN cycle -> no scan_done, en_mask = 8'hFF, score retained. respawn together with frame_tick -> state stays IDLE, scan_overrun = 0.
- SCORE_W = 4, preset to 15 by repeated collection/respawn, then one more touch -> score stays 15.
